// File: rtl/div_issue_retire_ctrl.sv
// Issue/in-flight/retire control around an 8-stage pipelined RV32M divider.
// Optional performance counters are enabled by defining DIV_PERF_CNT_EN.
module div_issue_retire_ctrl #(
    parameter int unsigned LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        i_valid,
    input  logic [1:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_div_signed,
    input  logic [31:0] i_quotient,
    input  logic [31:0] i_remainder,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic        o_hazard,
    output logic        o_busy,
    output logic        o_valid,
    output logic [4:0]  o_rd,
    output logic [31:0] o_result
`ifdef DIV_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_issued,
    output logic [31:0] o_perf_special
`endif
);
    localparam int unsigned Tail = LATENCY - 1;

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] is_rem_q;
    logic [LATENCY-1:0] special_q;
    logic [4:0]         rd_q   [LATENCY];
    logic [31:0]        spec_q [LATENCY];

    logic        load;
    logic        div_zero;
    logic        overflow;
    logic [31:0] spec_val;

    assign o_div_signed = ~i_op[0];
    // Writes to x0 travel as bubbles so they never retire or raise hazards.
    assign load     = i_valid & (i_rd != 5'd0);
    assign div_zero = (i_divisor == 32'd0);
    assign overflow = ~i_op[0] & (i_dividend == 32'h8000_0000) & (i_divisor == 32'hFFFF_FFFF);

    always_comb begin
        spec_val = 32'd0;
        if (div_zero) begin
            spec_val = i_op[1] ? i_dividend : 32'hFFFF_FFFF;
        end else if (overflow) begin
            spec_val = i_op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            is_rem_q  <= '0;
            special_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                rd_q[i]   <= 5'd0;
                spec_q[i] <= 32'd0;
            end
        end else if (!stall) begin
            valid_q   <= {valid_q[LATENCY-2:0], load};
            is_rem_q  <= {is_rem_q[LATENCY-2:0], i_op[1]};
            special_q <= {special_q[LATENCY-2:0], load & (div_zero | overflow)};
            rd_q[0]   <= load ? i_rd : 5'd0;
            spec_q[0] <= load ? spec_val : 32'd0;
            for (int i = 1; i < int'(LATENCY); i++) begin
                rd_q[i]   <= rd_q[i-1];
                spec_q[i] <= spec_q[i-1];
            end
        end
    end

    always_comb begin
        o_hazard = 1'b0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            if (valid_q[i] && (rd_q[i] != 5'd0) && ((rd_q[i] == i_rs1) || (rd_q[i] == i_rs2))) begin
                o_hazard = 1'b1;
            end
        end
    end

    assign o_busy  = |valid_q;
    assign o_valid = valid_q[Tail] & ~stall;
    assign o_rd    = rd_q[Tail];

    always_comb begin
        if (special_q[Tail]) begin
            o_result = spec_q[Tail];
        end else if (is_rem_q[Tail]) begin
            o_result = i_remainder;
        end else begin
            o_result = i_quotient;
        end
    end

`ifdef DIV_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_issued  <= 32'd0;
            o_perf_special <= 32'd0;
        end else if (i_valid && !stall) begin
            o_perf_issued <= o_perf_issued + 32'd1;
            if (div_zero || overflow) begin
                o_perf_special <= o_perf_special + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_issue_retire_ctrl.sv
// Self-checking bench for div_issue_retire_ctrl with a behavioural divider stand-in and scoreboard.
module tb_div_issue_retire_ctrl;
    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst, stall, i_valid;
    logic [1:0]  i_op;
    logic [4:0]  i_rd, i_rs1, i_rs2;
    logic [31:0] i_dividend, i_divisor, i_quotient, i_remainder;
    logic        o_div_signed, o_hazard, o_busy, o_valid;
    logic [4:0]  o_rd;
    logic [31:0] o_result;
`ifdef DIV_PERF_CNT_EN
    logic [31:0] o_perf_issued, o_perf_special;
    int unsigned exp_issued = 0, exp_special = 0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_issue_retire_ctrl #(.LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .i_valid      (i_valid),
        .i_op         (i_op),
        .i_rd         (i_rd),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_div_signed (o_div_signed),
        .i_quotient   (i_quotient),
        .i_remainder  (i_remainder),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .o_hazard     (o_hazard),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_rd         (o_rd),
`ifdef DIV_PERF_CNT_EN
        .o_perf_issued  (o_perf_issued),
        .o_perf_special (o_perf_special),
`endif
        .o_result     (o_result)
    );

    // Divider stand-in: 8 stages, junk outputs for special cases so the wrapper must override them.
    logic [31:0] dq [LAT];
    logic [31:0] dr [LAT];
    assign i_quotient  = dq[LAT-1];
    assign i_remainder = dr[LAT-1];

    always @(posedge clk) begin
        if (!stall) begin
            for (int i = LAT - 1; i > 0; i--) begin
                dq[i] <= dq[i-1];
                dr[i] <= dr[i-1];
            end
            if (i_divisor == 32'd0 ||
                (o_div_signed && i_dividend == 32'h8000_0000 && i_divisor == 32'hFFFF_FFFF)) begin
                dq[0] <= 32'h1234_5678;
                dr[0] <= 32'h9ABC_DEF0;
            end else if (o_div_signed) begin
                dq[0] <= $signed(i_dividend) / $signed(i_divisor);
                dr[0] <= $signed(i_dividend) % $signed(i_divisor);
            end else begin
                dq[0] <= i_dividend / i_divisor;
                dr[0] <= i_dividend % i_divisor;
            end
        end
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic sgn;
        logic rem;
        sgn = ~op[0];
        rem = op[1];
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return rem ? a % b : a / b;
    endfunction

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] edge_n;
    } exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
    } ret_t;

    exp_t        sb[$];
    ret_t        ret_q[$];
    int unsigned adv_cnt = 0;
    int unsigned nz_issued = 0;

    // Capture side of the model: one entry per accepted issue that writes a real register.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
`ifdef DIV_PERF_CNT_EN
            exp_issued  = 0;
            exp_special = 0;
`endif
        end else if (!stall) begin
            adv_cnt <= adv_cnt + 1;
            if (i_valid) begin
                if (i_rd != 5'd0) begin
                    e.rd     = i_rd;
                    e.res    = ref_result(i_op, i_dividend, i_divisor);
                    e.edge_n = adv_cnt + 1;
                    sb.push_back(e);
                    nz_issued++;
                end
`ifdef DIV_PERF_CNT_EN
                exp_issued++;
                if (i_divisor == 32'd0 ||
                    (!i_op[0] && i_dividend == 32'h8000_0000 && i_divisor == 32'hFFFF_FFFF))
                    exp_special++;
`endif
            end
        end
    end

    // Retire side: every cycle compare hazard/busy against in-flight set and check each retirement.
    always @(negedge clk) begin
        logic exp_haz;
        exp_t e;
        ret_t r;
        if (!rst) begin
            exp_haz = 1'b0;
            foreach (sb[k]) if (sb[k].rd == i_rs1 || sb[k].rd == i_rs2) exp_haz = 1'b1;
            checks += 3;
            if (o_hazard !== exp_haz) begin
                errors++;
                $display("FAIL mon_hazard: got %b expected %b (t=%0t)", o_hazard, exp_haz, $time);
            end
            if (o_busy !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL mon_busy: got %b expected %b (t=%0t)", o_busy, sb.size() != 0, $time);
            end
            if (stall && o_valid !== 1'b0) begin
                errors++;
                $display("FAIL mon_stall_valid: got %b expected 0 (t=%0t)", o_valid, $time);
            end
            if (o_valid === 1'b1) begin
                r.rd  = o_rd;
                r.res = o_result;
                ret_q.push_back(r);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_stale: o_valid=1 rd=%0d res=%h with nothing expected in flight",
                             o_rd, o_result);
                end else begin
                    e = sb.pop_front();
                    checks += 2;
                    if (o_rd !== e.rd || o_result !== e.res) begin
                        errors++;
                        $display("FAIL mon_retire: got rd=%0d res=%h expected rd=%0d res=%h",
                                 o_rd, o_result, e.rd, e.res);
                    end
                    if (adv_cnt - e.edge_n != LAT - 1) begin
                        errors++;
                        $display("FAIL mon_latency: got %0d edges to tail expected %0d",
                                 adv_cnt - e.edge_n, LAT - 1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        i_valid    = v;
        i_op       = op;
        i_rd       = rd;
        i_dividend = a;
        i_divisor  = b;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b pending=%0d expected idle", o_busy, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; i_rs1 = 5'd0; i_rs2 = 5'd0;
        drive(1'b1, 2'b00, 5'd9, 32'd10, 32'd3);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd1);
        checks += 4;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        if (o_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", o_hazard); end
        if (o_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", o_rd); end
`ifdef DIV_PERF_CNT_EN
        checks += 2;
        if (o_perf_issued !== 32'd0) begin errors++; $display("FAIL reset_perf_issued: got %0d expected 0", o_perf_issued); end
        if (o_perf_special !== 32'd0) begin errors++; $display("FAIL reset_perf_special: got %0d expected 0", o_perf_special); end
`endif
    endtask

    task automatic test_basic();
        int n;
        logic [31:0] exp_res [2];
        logic [1:0]  ops [2];
        exp_res[0] = 32'hFFFF_FFFD; ops[0] = 2'b00;
        exp_res[1] = 32'hFFFF_FFFF; ops[1] = 2'b10;
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, ops[t], 5'd3, 32'hFFFF_FFF9, 32'd2);
            checks++;
            if (o_div_signed !== 1'b1) begin errors++; $display("FAIL basic_signed: got %b expected 1", o_div_signed); end
            tick();
            i_valid = 1'b0;
            n = 0;
            while (o_valid !== 1'b1 && n < 20) begin tick(); n++; end
            checks += 3;
            if (n != LAT - 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", n, LAT - 1); end
            if (o_rd !== 5'd3) begin errors++; $display("FAIL basic_rd: got %0d expected 3", o_rd); end
            if (o_result !== exp_res[t]) begin errors++; $display("FAIL basic_result: got %h expected %h", o_result, exp_res[t]); end
            tick();
        end
        i_op = 2'b01;
        #1;
        checks++;
        if (o_div_signed !== 1'b0) begin errors++; $display("FAIL basic_unsigned: got %b expected 0", o_div_signed); end
        wait_idle();
    endtask

    task automatic test_div_zero();
        logic [1:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] ex  [4];
        ops[0] = 2'b01; as[0] = 32'd100;       ex[0] = 32'hFFFF_FFFF;
        ops[1] = 2'b00; as[1] = 32'hFFFF_FFFB; ex[1] = 32'hFFFF_FFFF;
        ops[2] = 2'b10; as[2] = 32'hFFFF_FFFB; ex[2] = 32'hFFFF_FFFB;
        ops[3] = 2'b11; as[3] = 32'd7;         ex[3] = 32'd7;
        ret_q.delete();
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, ops[t], 5'(6 + t), as[t], 32'd0);
            tick();
        end
        i_valid = 1'b0;
        wait_idle();
        checks++;
        if (ret_q.size() != 4) begin
            errors++; $display("FAIL dz_count: got %0d expected 4", ret_q.size());
        end else begin
            for (int t = 0; t < 4; t++) begin
                checks++;
                if (ret_q[t].res !== ex[t] || ret_q[t].rd !== 5'(6 + t)) begin
                    errors++;
                    $display("FAIL dz_result%0d: got rd=%0d %h expected rd=%0d %h", t, ret_q[t].rd,
                             ret_q[t].res, 6 + t, ex[t]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ex [4];
        ex[0] = 32'h8000_0000; ex[1] = 32'h0000_0000; ex[2] = 32'h0000_0000; ex[3] = 32'h8000_0000;
        ret_q.delete();
        // op order DIV, DIVU, REM, REMU
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, 2'(t), 5'(10 + t), 32'h8000_0000, 32'hFFFF_FFFF);
            tick();
        end
        i_valid = 1'b0;
        wait_idle();
        checks++;
        if (ret_q.size() != 4) begin
            errors++; $display("FAIL ovf_count: got %0d expected 4", ret_q.size());
        end else begin
            for (int t = 0; t < 4; t++) begin
                checks++;
                if (ret_q[t].res !== ex[t]) begin
                    errors++; $display("FAIL ovf_result%0d: got %h expected %h", t, ret_q[t].res, ex[t]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [4:0]  cap_rd;
        logic [31:0] cap_res;
        int unsigned a, b, ex;
        ret_q.delete();
        for (int i = 1; i <= 8; i++) begin
            a = 1000 + i * 37;
            b = i + 2;
            drive(1'b1, (i % 2 == 1) ? 2'b11 : 2'b01, 5'(i), a, b);
            if (i == 5) begin
                stall = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checks++;
                    if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_stall_valid: got %b expected 0", o_valid); end
                end
                stall = 1'b0;
            end
            tick();
        end
        i_valid = 1'b0;
        n = 0;
        while (o_valid !== 1'b1 && n < 20) begin tick(); n++; end
        cap_rd  = o_rd;
        cap_res = o_result;
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            #2;
            checks += 3;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold_valid: got %b expected 0", o_valid); end
            if (o_rd !== cap_rd) begin errors++; $display("FAIL b2b_hold_rd: got %0d expected %0d", o_rd, cap_rd); end
            if (o_result !== cap_res) begin errors++; $display("FAIL b2b_hold_res: got %h expected %h", o_result, cap_res); end
            tick();
        end
        stall = 1'b0;
        wait_idle();
        checks++;
        if (ret_q.size() != 8) begin
            errors++; $display("FAIL b2b_count: got %0d expected 8", ret_q.size());
        end else begin
            for (int i = 1; i <= 8; i++) begin
                a = 1000 + i * 37;
                b = i + 2;
                ex = (i % 2 == 1) ? a % b : a / b;
                checks++;
                if (ret_q[i-1].rd !== 5'(i) || ret_q[i-1].res !== ex) begin
                    errors++;
                    $display("FAIL b2b_order%0d: got rd=%0d %h expected rd=%0d %h", i, ret_q[i-1].rd,
                             ret_q[i-1].res, i, ex);
                end
            end
        end
    endtask

    task automatic test_hazard();
        int cnt;
        i_rs1 = 5'd5;
        i_rs2 = 5'd31;
        drive(1'b1, 2'b00, 5'd5, 32'd50, 32'd5);
        tick();
        i_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (o_hazard === 1'b1) cnt++;
            tick();
        end
        checks += 2;
        if (cnt != LAT) begin errors++; $display("FAIL hazard_cycles: got %0d expected %0d", cnt, LAT); end
        if (o_hazard !== 1'b0) begin errors++; $display("FAIL hazard_clear: got %b expected 0", o_hazard); end
        ret_q.delete();
        i_rs1 = 5'd0;
        i_rs2 = 5'd0;
        drive(1'b1, 2'b00, 5'd0, 32'd9, 32'd3);
        tick();
        i_valid = 1'b0;
        checks += 2;
        if (o_hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard: got %b expected 0", o_hazard); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", o_busy); end
        repeat (LAT + 2) tick();
        checks++;
        if (ret_q.size() != 0) begin errors++; $display("FAIL x0_retire: got %0d retirements expected 0", ret_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 2'(t), 5'(20 + t), 32'd77 + 32'(t), 32'd4);
            tick();
        end
        i_valid = 1'b0;
        i_rs1 = 5'd20;
        repeat (4) tick();
        rst = 1'b1;
        drive(1'b1, 2'b00, 5'd21, 32'd1, 32'd1);
        tick();
        rst = 1'b0;
        i_valid = 1'b0;
        ret_q.delete();
        checks += 4;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", o_valid); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
        if (o_hazard !== 1'b0) begin errors++; $display("FAIL rstmid_hazard: got %b expected 0", o_hazard); end
        if (o_rd !== 5'd0) begin errors++; $display("FAIL rstmid_rd: got %0d expected 0", o_rd); end
`ifdef DIV_PERF_CNT_EN
        checks += 2;
        if (o_perf_issued !== 32'd0) begin errors++; $display("FAIL rstmid_perf_issued: got %0d expected 0", o_perf_issued); end
        if (o_perf_special !== 32'd0) begin errors++; $display("FAIL rstmid_perf_special: got %0d expected 0", o_perf_special); end
`endif
        repeat (12) tick();
        checks++;
        if (ret_q.size() != 0) begin errors++; $display("FAIL rstmid_stale: got %0d retirements expected 0", ret_q.size()); end
        i_rs1 = 5'd0;
    endtask

    task automatic test_random();
        int unsigned base;
        logic [31:0] a, b;
        int sel;
        ret_q.delete();
        base = nz_issued;
        for (int c = 0; c < 400; c++) begin
            sel = int'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'hFFFF_FFFF;
            else if (sel == 3) b = $urandom_range(1, 9);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), a, b);
            stall = ($urandom_range(0, 3) == 0);
            i_rs1 = 5'($urandom_range(0, 31));
            i_rs2 = 5'($urandom_range(0, 31));
            tick();
        end
        i_valid = 1'b0;
        stall = 1'b0;
        wait_idle();
        checks++;
        if (ret_q.size() != int'(nz_issued - base)) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", ret_q.size(), nz_issued - base);
        end
`ifdef DIV_PERF_CNT_EN
        checks += 2;
        if (o_perf_issued !== exp_issued) begin errors++; $display("FAIL perf_issued: got %0d expected %0d", o_perf_issued, exp_issued); end
        if (o_perf_special !== exp_special) begin errors++; $display("FAIL perf_special: got %0d expected %0d", o_perf_special, exp_special); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
